div6_restoring_ctrl: RTL and testbench

Sequential 6-bit unsigned restoring divider that drives the 6-bit borrow-ripple subtractor stage. Each iteration it presents the operands to that stage and consumes its difference and borrow-out. It accepts a dividend/divisor pair on a start pulse and performs one quotient bit per clock for 6 clocks. It returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It sits between the operand source (register file or bench) and the subtractor, owning all sequencing; the subtractor stays purely combinational.

---
 rtl/div6_restoring_ctrl.sv | 72 +++++++
 tb/tb_div6_restoring_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/div6_restoring_ctrl.sv
// div6_restoring_ctrl: 6-bit restoring divider sequencing an external combinational borrow-ripple subtractor
module div6_restoring_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] dividend,
  input  logic [5:0] divisor,
  output logic [5:0] sub_a,
  output logic [5:0] sub_b,
  input  logic [5:0] sub_d,
  input  logic       sub_bout,
  output logic       busy,
  output logic       done,
  output logic [5:0] quotient,
  output logic [5:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] r, q, d;
  logic [2:0] cnt;
  logic [6:0] s;
  logic       acc;
  logic [5:0] r_nx, q_nx;
  assign s    = {r, q[5]};
  // s[6] set means the shifted remainder already exceeds any 6-bit divisor
  assign acc  = s[6] | ~sub_bout;
  assign r_nx = acc ? sub_d : s[5:0];
  assign q_nx = {q[4:0], acc};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? (divisor == '0 ? DONE : ITER) : IDLE) :
               state == ITER ? (cnt == 3'd5 ? DONE : ITER) : IDLE;
  always_comb begin
    busy  = state == ITER;
    done  = state == DONE;
    sub_a = busy ? s[5:0] : '0;
    sub_b = busy ? d : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      if (divisor != '0) begin
        r   <= '0;
        q   <= dividend;
        d   <= divisor;
        cnt <= '0;
      end else begin
        quotient    <= 6'h3f;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == ITER) begin
      r   <= r_nx;
      q   <= q_nx;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd5) begin
        quotient    <= q_nx;
        remainder   <= r_nx;
        div_by_zero <= 1'b0;
      end
    end
endmodule

// File: tb/tb_div6_restoring_ctrl.sv
// tb_div6_restoring_ctrl: random and directed divisions checked against an arithmetic reference
module tb_div6_restoring_ctrl;
  logic       clk = 0, rst_n = 0, start = 0;
  logic [5:0] dividend = 0, divisor = 0;
  logic [5:0] sub_a, sub_b, sub_d;
  logic       sub_bout, busy, done, div_by_zero;
  logic [5:0] quotient, remainder;
  int total = 0, bad = 0;

  div6_restoring_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .sub_a(sub_a), .sub_b(sub_b), .sub_d(sub_d), .sub_bout(sub_bout),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  assign sub_d    = sub_a - sub_b;
  assign sub_bout = sub_a < sub_b;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ph counts cycles since launch (0 idle, 1..6 iterating, 7 done)
  int ph = 0, ma = 0, mb = 0, exp_q = 0, exp_r = 0, exp_z = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph <= 0; exp_q <= 0; exp_r <= 0; exp_z <= 0;
    end else if (ph == 0) begin
      if (start) begin
        ma <= int'(dividend);
        mb <= int'(divisor);
        if (divisor == 0) begin
          ph <= 7; exp_q <= 63; exp_r <= int'(dividend); exp_z <= 1;
        end else ph <= 1;
      end
    end else if (ph < 6) ph <= ph + 1;
    else if (ph == 6) begin
      ph <= 7; exp_q <= ma / mb; exp_r <= ma % mb; exp_z <= 0;
    end else ph <= 0;

  function automatic int exp_sub_a(int k);
    int s;
    s = 2 * ((ma >> (6 - k)) % mb) + ((ma >> (5 - k)) & 1);
    return s % 64;
  endfunction

  always @(negedge clk) begin
    automatic int b = (ph >= 1 && ph <= 6) ? 1 : 0;
    chk("busy", int'(busy), b);
    chk("done", int'(done), ph == 7 ? 1 : 0);
    chk("quotient", int'(quotient), exp_q);
    chk("remainder", int'(remainder), exp_r);
    chk("div_by_zero", int'(div_by_zero), exp_z);
    chk("sub_a", int'(sub_a), b ? exp_sub_a(ph - 1) : 0);
    chk("sub_b", int'(sub_b), b ? mb : 0);
  end

  task automatic launch(input int a, input int b);
    @(negedge clk);
    dividend = 6'(a); divisor = 6'(b); start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0; nb = 0;
    while (!done) begin
      if (busy) nb++;
      if (lat >= 20) begin
        chk("done_timeout", lat, -1);
        return;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input int a, input int b, input int eq, input int er, input int ez);
    int lat, nb;
    launch(a, b);
    wait_done(lat, nb);
    chk("lit_q", int'(quotient), eq);
    chk("lit_r", int'(remainder), er);
    chk("lit_z", int'(div_by_zero), ez);
    chk("latency", lat, b != 0 ? 6 : 0);
    chk("busy_cycles", nb, b != 0 ? 6 : 0);
  endtask

  initial begin
    int n, a, b;
    #2;
    chk("rst_q", int'(quotient), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run(45, 7, 6, 3, 0);
    run(63, 1, 63, 0, 0);
    run(5, 9, 0, 5, 0);
    run(0, 5, 0, 0, 0);
    run(63, 34, 1, 29, 0);
    run(62, 33, 1, 29, 0);
    run(63, 0, 63, 63, 1);
    run(10, 3, 3, 1, 0);
    // start pulsed while busy is ignored
    launch(45, 7);
    repeat (2) @(negedge clk);
    dividend = 9; divisor = 2; start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("single_done", n, 1);
    chk("held_q", int'(quotient), 6);
    chk("held_r", int'(remainder), 3);
    run(9, 2, 4, 1, 0);
    // asynchronous reset mid-operation
    launch(45, 7);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_q", int'(quotient), 0);
    chk("arst_r", int'(remainder), 0);
    chk("arst_sub_a", int'(sub_a), 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n++;
    end
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_done_after_rst", n, 0);
    run(20, 6, 3, 2, 0);
    // random single operations
    repeat (60) begin
      a = $urandom_range(0, 63);
      b = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 63);
      run(a, b, b != 0 ? a / b : 63, b != 0 ? a % b : a, b == 0 ? 1 : 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    // start held high: back-to-back relaunches checked cycle by cycle
    @(negedge clk);
    start = 1;
    repeat (80) begin
      dividend = 6'($urandom_range(0, 63));
      divisor = $urandom_range(0, 3) == 0 ? 6'd0 : 6'($urandom_range(1, 63));
      @(negedge clk);
    end
    start = 0;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
